reg_bank_poci: RTL and testbench

REG_BANK_POCI -- requirements
Module: reg_bank_poci

---
 rtl/reg_bank_poci.sv | 245 ++++++++++++++++++++++++
 tb/tb_reg_bank_poci.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_poci.sv
// reg_bank_poci
//    A bank of NREG 8-bit registers. Writes arrive from the PICO stage as a
//    valid/ready handshake. Reads come back as a serial PICO-out stream,
//    MSB first. Register 0 is a fixed identification byte (ID_VALUE) and
//    cannot be written. Addresses at or above NREG read as 8'h00 and drop
//    any write to them.
//
//    A read-out starts with rd_start. It shifts one byte out over 8 cycles
//    and pulses rd_done for one cycle once the byte is complete. If
//    rd_burst is high when a byte ends, the next byte is loaded from the
//    following address, wrapping modulo NREG. That byte follows with no
//    gap.
//
//    Optional feature, enabled by defining the macro REG_PARITY_EN:
//    an odd-parity bit follows the 8 data bits (state PAR), so each byte
//    takes 9 cycles. rd_done and the burst decision then happen when PAR
//    ends. With the macro undefined there is no parity logic at all.
//
// Parameters
//    NREG      number of registers, power of two in 2..256
//    ID_VALUE  read-only contents of register 0
//
// Ports
//    iclk      clock, rising edge active
//    rst       synchronous active-high reset
//    wr_valid  write request
//    wr_ready  write accept; low during reset and for the first cycle after
//    wr_addr   write target register
//    wr_data   write payload
//    rd_start  start a read-out (ignored unless idle)
//    rd_addr   first register to read
//    rd_burst  continue with the next address after the current byte
//    poci_out  serial read data, MSB first, 0 when idle
//    rd_busy   serializer active
//    rd_done   one-cycle pulse after each byte

`timescale 1ns/1ps

module reg_bank_poci #(
   parameter int         NREG     = 32,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic       iclk,
   input  logic       rst,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       rd_start,
   input  logic [7:0] rd_addr,
   input  logic       rd_burst,
   output logic       poci_out,
   output logic       rd_busy,
   output logic       rd_done
);

   localparam int         AW        = (NREG > 2) ? $clog2(NREG) : 1;
   localparam logic [8:0] NREG_W    = 9'(NREG);
   localparam logic [7:0] ADDR_MASK = 8'(NREG - 1);

`ifdef REG_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] addr_q, addr_d;
   logic       rd_done_q, rd_done_d;
   logic       wr_ready_q, wr_ready_d;
   logic [7:0] regs_q [NREG];
   logic [7:0] regs_d [NREG];
`ifdef REG_PARITY_EN
   logic       par_q, par_d;
`endif

   logic       wr_fire;
   logic       wr_hit;
   logic [7:0] start_data;
   logic [7:0] next_addr;
   logic [7:0] next_data;
   logic       byte_end;
   logic       poci_bit;

   // A write completes whenever the handshake is met. It only changes
   // storage when the target is a writable register: not 0, and in range.
   // Reset takes priority over a write in the same cycle.
   assign wr_fire = wr_valid && wr_ready_q && !rst;
   assign wr_hit  = wr_fire && (wr_addr != 8'd0) && ({1'b0, wr_addr} < NREG_W);

   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[wr_addr[AW-1:0]] = wr_data;
      end
   end

   // Read port for the first byte of a read-out. It reads the registered
   // contents, so a write to the same register in the same cycle is not
   // seen until the next cycle.
   always_comb begin
      start_data = 8'h00;
      if ({1'b0, rd_addr} >= NREG_W) begin
         start_data = 8'h00;
      end else if (rd_addr == 8'd0) begin
         start_data = ID_VALUE;
      end else begin
         start_data = regs_q[rd_addr[AW-1:0]];
      end
   end

   // Read port for burst continuation. The address increments in 8 bits
   // and is then folded into range. This is how a burst that starts at an
   // out-of-range address gets back into the bank.
   always_comb begin
      next_addr = (addr_q + 8'd1) & ADDR_MASK;
      next_data = (next_addr == 8'd0) ? ID_VALUE : regs_q[next_addr[AW-1:0]];
   end

   // Serializer next-state logic. byte_end marks the edge where the last
   // cycle of a byte leaves. That cycle is the 8th data bit, or the parity
   // bit when parity is enabled. At that edge rd_done is raised and the
   // burst decision is made.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      addr_d     = addr_q;
      rd_done_d  = 1'b0;
      wr_ready_d = !rst;
      byte_end   = 1'b0;
`ifdef REG_PARITY_EN
      par_d      = par_q;
`endif

      case (state_q)
         IDLE: begin
            if (rd_start) begin
               shift_d   = start_data;
               addr_d    = rd_addr;
               bit_cnt_d = 3'd0;
`ifdef REG_PARITY_EN
               par_d     = ~^start_data;
`endif
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef REG_PARITY_EN
               state_d = PAR;
`else
               byte_end = 1'b1;
`endif
            end
         end
`ifdef REG_PARITY_EN
         PAR: begin
            byte_end = 1'b1;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      if (byte_end) begin
         rd_done_d = 1'b1;
         if (rd_burst) begin
            shift_d   = next_data;
            addr_d    = next_addr;
            bit_cnt_d = 3'd0;
`ifdef REG_PARITY_EN
            par_d     = ~^next_data;
`endif
            state_d   = SHIFT;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // All state lives here. Reset clears the writable registers, drops any
   // byte in flight without a rd_done pulse, and withdraws wr_ready.
   always_ff @(posedge iclk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         addr_q     <= 8'h00;
         rd_done_q  <= 1'b0;
         wr_ready_q <= 1'b0;
`ifdef REG_PARITY_EN
         par_q      <= 1'b0;
`endif
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         addr_q     <= addr_d;
         rd_done_q  <= rd_done_d;
         wr_ready_q <= wr_ready_d;
`ifdef REG_PARITY_EN
         par_q      <= par_d;
`endif
         regs_q     <= regs_d;
      end
   end

   // Serial output. It carries the data MSB in SHIFT and the parity bit in
   // PAR, and is 0 otherwise.
   always_comb begin
      poci_bit = 1'b0;
      case (state_q)
         SHIFT:   poci_bit = shift_q[7];
`ifdef REG_PARITY_EN
         PAR:     poci_bit = par_q;
`endif
         default: poci_bit = 1'b0;
      endcase
   end

   // Outputs are forced quiet while reset is asserted. This also covers
   // the cycle in which reset first arrives, while the state registers
   // still hold their old values.
   assign poci_out = !rst && poci_bit;
   assign rd_busy  = !rst && (state_q != IDLE);
   assign rd_done  = !rst && rd_done_q;
   assign wr_ready = !rst && wr_ready_q;

endmodule

// File: tb/tb_reg_bank_poci.sv
// tb_reg_bank_poci
//    Scoreboard bench for reg_bank_poci.
//
//    Each read request turns the reference register image into the exact
//    per-cycle stream it should produce: rd_busy, poci_out and rd_done.
//    That stream goes into a queue. A monitor on the falling clock edge
//    pops one entry whenever the DUT shows rd_busy or rd_done and compares
//    the two. Directed scenarios come first, then a randomized mix of
//    writes and burst reads.

`timescale 1ns/1ps

module tb_reg_bank_poci;

   localparam int         NREG = 32;
   localparam logic [7:0] ID   = 8'hA5;
`ifdef REG_PARITY_EN
   localparam int         BC   = 9;
`else
   localparam int         BC   = 8;
`endif

   logic       iclk;
   logic       rst;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_start;
   logic [7:0] rd_addr;
   logic       rd_burst;
   logic       poci_out;
   logic       rd_busy;
   logic       rd_done;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mregs [256];
   logic [2:0] expQ [$];
   logic [2:0] monEntry;

   reg_bank_poci #(
      .NREG     (NREG),
      .ID_VALUE (ID)
   ) dut (
      .iclk     (iclk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_start (rd_start),
      .rd_addr  (rd_addr),
      .rd_burst (rd_burst),
      .poci_out (poci_out),
      .rd_busy  (rd_busy),
      .rd_done  (rd_done)
   );

   // Free-running clock, 10 ns period
   initial begin
      iclk = 1'b0;
      forever #5 iclk = ~iclk;
   end

   // Every comparison goes through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what a register read returns, and where a burst goes next
   function automatic logic [7:0] modelRead(input int a);
      if (a >= NREG) return 8'h00;
      if (a == 0) return ID;
      return mregs[a];
   endfunction

   function automatic int modelNext(input int a);
      return ((a + 1) % 256) % NREG;
   endfunction

   task automatic modelWrite(input int a, input logic [7:0] d);
      if (a != 0 && a < NREG) mregs[a] = d;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
   endtask

   // Expected cycles of one byte: {busy, bit, done}. rd_done from the
   // previous byte shows up on the first bit of the next byte.
   task automatic pushByte(input logic [7:0] v, input bit first);
      for (int b = 7; b >= 0; b--) begin
         expQ.push_back({1'b1, v[b], (b == 7) && !first});
      end
`ifdef REG_PARITY_EN
      expQ.push_back({1'b1, ~^v, 1'b0});
`endif
   endtask

   // Scoreboard monitor: compares on every cycle the DUT reports activity
   always @(negedge iclk) begin
      if (rd_busy === 1'b1 || rd_done === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL serial_extra: got busy=%b poci=%b done=%b with nothing expected at %0t",
                     rd_busy, poci_out, rd_done, $time);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("serial", {29'd0, rd_busy, poci_out, rd_done}, {29'd0, monEntry});
         end
      end
   end

   // Wait, with a bounded number of cycles, for the expected stream to be consumed
   task automatic drain();
      for (int i = 0; i < 80 && expQ.size() != 0; i++) @(posedge iclk);
      #1;
      checkOutput("drain_left", expQ.size(), 0);
      expQ.delete();
   endtask

   task automatic resetDut();
      rst = 1'b1;
      @(negedge iclk);
      checkOutput("rst_poci", {31'd0, poci_out}, 0);
      checkOutput("rst_busy", {31'd0, rd_busy}, 0);
      checkOutput("rst_done", {31'd0, rd_done}, 0);
      checkOutput("rst_wr_ready", {31'd0, wr_ready}, 0);
      @(posedge iclk); #1;
      rst = 1'b0;
      modelReset();
      @(posedge iclk); #1;
   endtask

   task automatic writeReg(input int a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr  = 8'(a);
      wr_data  = d;
      @(negedge iclk);
      checkOutput("wr_ready", {31'd0, wr_ready}, 1);
      @(posedge iclk); #1;
      wr_valid = 1'b0;
      modelWrite(a, d);
   endtask

   // Read n bytes from address a. Optionally pulse rd_start mid-byte (it
   // must be ignored). Optionally write (wa, wd) at the same edge as the start.
   task automatic readBytes(input int a, input int n, input bit pulse,
                            input bit doWr, input int wa, input logic [7:0] wd);
      int cur;
      int elapsed;
      cur = a;
      pushByte(modelRead(cur), 1'b1);
      if (doWr) modelWrite(wa, wd);
      for (int j = 1; j < n; j++) begin
         cur = modelNext(cur);
         pushByte(modelRead(cur), 1'b0);
      end
      expQ.push_back(3'b001);

      rd_start = 1'b1;
      rd_addr  = 8'(a);
      rd_burst = (n > 1);
      if (doWr) begin
         wr_valid = 1'b1;
         wr_addr  = 8'(wa);
         wr_data  = wd;
      end
      @(negedge iclk);
      if (doWr) checkOutput("wr_ready_rd", {31'd0, wr_ready}, 1);
      @(posedge iclk); #1;
      rd_start = 1'b0;
      wr_valid = 1'b0;
      elapsed  = 0;
      if (pulse) begin
         @(posedge iclk); #1;
         rd_start = 1'b1;
         rd_addr  = 8'($urandom_range(0, 255));
         @(posedge iclk); #1;
         rd_start = 1'b0;
         elapsed  = 2;
      end
      if (n > 1) begin
         repeat ((n - 1) * BC - elapsed) @(posedge iclk);
         #1;
         rd_burst = 1'b0;
      end
      drain();
   endtask

   // Read address 5 and assert reset while its 4th bit is on the line
   task automatic resetMidByte();
      logic [7:0] v;
      v = modelRead(5);
      for (int b = 7; b >= 5; b--) expQ.push_back({1'b1, v[b], 1'b0});
      rd_start = 1'b1;
      rd_addr  = 8'd5;
      rd_burst = 1'b0;
      @(posedge iclk); #1;
      rd_start = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      rst = 1'b1;
      @(negedge iclk);
      checkOutput("midrst_poci", {31'd0, poci_out}, 0);
      checkOutput("midrst_busy", {31'd0, rd_busy}, 0);
      checkOutput("midrst_done", {31'd0, rd_done}, 0);
      checkOutput("midrst_wr_ready", {31'd0, wr_ready}, 0);
      @(posedge iclk); #1;
      rst = 1'b0;
      modelReset();
      @(negedge iclk);
      checkOutput("postrst_poci", {31'd0, poci_out}, 0);
      checkOutput("postrst_busy", {31'd0, rd_busy}, 0);
      checkOutput("postrst_done", {31'd0, rd_done}, 0);
      @(posedge iclk); #1;
      checkOutput("midrst_left", expQ.size(), 0);
      expQ.delete();
   endtask

   // Randomized mix of writes and (burst) reads, some overlapped with a write
   task automatic applyStimulus();
      int a;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            writeReg($urandom_range(0, 63), 8'($urandom_range(0, 255)));
         end else begin
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(248, 255) : $urandom_range(0, 63);
            readBytes(a, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 63),
                      8'($urandom_range(0, 255)));
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_addr  = 8'h00;
      wr_data  = 8'h00;
      rd_start = 1'b0;
      rd_addr  = 8'h00;
      rd_burst = 1'b0;
      modelReset();

      resetDut();

      // Basic write then single-byte read
      writeReg(5, 8'h3C);
      readBytes(5, 1, 1'b0, 1'b0, 0, 8'h00);

      // Read-only ID register and an out-of-range address
      writeReg(0, 8'hFF);
      writeReg(40, 8'h12);
      readBytes(0, 1, 1'b0, 1'b0, 0, 8'h00);
      readBytes(40, 1, 1'b0, 1'b0, 0, 8'h00);

      // Burst wrapping from the top register to 0 and 1
      writeReg(31, 8'h81);
      writeReg(1, 8'h7E);
      readBytes(31, 3, 1'b0, 1'b0, 0, 8'h00);

      // Write and load of the same register at the same edge
      writeReg(3, 8'hAA);
      readBytes(3, 1, 1'b0, 1'b1, 3, 8'h55);
      readBytes(3, 1, 1'b0, 1'b0, 0, 8'h00);

      // Reset in the middle of a byte, then register 5 must be cleared
      resetMidByte();
      readBytes(5, 1, 1'b0, 1'b0, 0, 8'h00);

      // Parity-sensitive values, read as a burst
      writeReg(6, 8'h03);
      writeReg(7, 8'h07);
      readBytes(6, 2, 1'b0, 1'b0, 0, 8'h00);

      // Bursts that start out of range, plus an ignored rd_start mid-byte
      writeReg(9, 8'hC3);
      readBytes(40, 2, 1'b1, 1'b0, 0, 8'h00);
      readBytes(255, 2, 1'b0, 1'b0, 0, 8'h00);

      applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not finish in time at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
